// File: rtl/mesh_traffic_ctrl.sv
// Traffic-pattern sequencer for an N-PE mesh NoC.
// Derives per-PE destination sequences and packet counts from node IDs, then runs the
// flush -> settle -> enable -> wait-for-finish sequence and reports completion, timeout
// and run length.
module mesh_traffic_ctrl #(
   parameter int unsigned PE_NUM     = 8,
   parameter int unsigned ADDR_W     = 3,
   parameter int unsigned NUM_W      = 3,
   parameter int unsigned SEQ_LEN    = 8,
   parameter int unsigned RATE_W     = 4,
   parameter int unsigned MODE_W     = 4,
   parameter int unsigned FLUSH_CYC  = 4,
   parameter int unsigned SETTLE_CYC = 50,
   parameter int unsigned CNT_W      = 16
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic                             start,
   input  logic [2:0]                       pattern_sel,
   input  logic [NUM_W-1:0]                 cfg_num,
   input  logic [RATE_W-1:0]                cfg_rate,
   input  logic [MODE_W-1:0]                cfg_mode,
   input  logic                             cfg_dbg,
   input  logic [ADDR_W-1:0]                hotspot_id,
   input  logic [CNT_W-1:0]                 timeout_lim,
   output logic [PE_NUM-1:0]                pe_enable,
   output logic [PE_NUM-1:0]                pe_dbg_mode_wire,
   output logic [PE_NUM*NUM_W-1:0]          pe_send_num_wire,
   output logic [PE_NUM*NUM_W-1:0]          pe_receive_num_wire,
   output logic [PE_NUM*RATE_W-1:0]         pe_rate_wire,
   output logic [PE_NUM*SEQ_LEN*ADDR_W-1:0] pe_dst_seq_wire,
   output logic [PE_NUM*MODE_W-1:0]         pe_mode_wire,
   output logic [PE_NUM-1:0]                pe_flush_wire,
   input  logic [PE_NUM-1:0]                pe_task_send_finish_flag,
   input  logic [PE_NUM-1:0]                pe_task_receive_finish_flag,
   output logic                             busy,
   output logic                             done,
   output logic                             timeout,
   output logic [CNT_W-1:0]                 cycle_count
);

   localparam int unsigned SeqW  = SEQ_LEN * ADDR_W;
   localparam int unsigned ProdW = NUM_W + ADDR_W;
   localparam int unsigned PhMax = (FLUSH_CYC > SETTLE_CYC) ? FLUSH_CYC : SETTLE_CYC;
   localparam int unsigned PhW   = $clog2(PhMax + 1);

   localparam logic [2:0] PatComplement = 3'd0;
   localparam logic [2:0] PatReverse    = 3'd1;
   localparam logic [2:0] PatRotation   = 3'd2;
   localparam logic [2:0] PatShuffle    = 3'd3;
   localparam logic [2:0] PatTornado    = 3'd4;
   localparam logic [2:0] PatNeighbor   = 3'd5;
   localparam logic [2:0] PatHotspot    = 3'd6;

   typedef enum logic [2:0] {
      StIdle,
      StFlush,
      StSettle,
      StRun,
      StDone
   } state_e;

   state_e               state_q;
   logic [PhW-1:0]       timer_q;
   logic [CNT_W-1:0]     lim_q;
   logic                 accept;
   logic                 all_finished;
   logic [CNT_W-1:0]     cnt_inc;

   logic [PE_NUM*SeqW-1:0]  dst_seq_d;
   logic [PE_NUM*NUM_W-1:0] send_d;
   logic [PE_NUM*NUM_W-1:0] recv_d;
   logic [ProdW-1:0]        hot_prod;
   logic [NUM_W-1:0]        hot_recv;

   assign accept       = (state_q == StIdle) && start;
   assign busy         = (state_q != StIdle);
   assign all_finished = (&pe_task_send_finish_flag) & (&pe_task_receive_finish_flag);
   assign cnt_inc      = (&cycle_count) ? cycle_count : cycle_count + CNT_W'(1);

   // Destination of node id under the selected pattern; all arithmetic wraps mod PE_NUM.
   function automatic logic [ADDR_W-1:0] dst_of(input logic [ADDR_W-1:0] id,
                                                input logic [2:0]        sel,
                                                input logic [ADDR_W-1:0] hot);
      logic [ADDR_W-1:0] rev;
      logic [ADDR_W-1:0] ror;
      logic [ADDR_W-1:0] rol;
      for (int b = 0; b < int'(ADDR_W); b++) begin
         rev[b] = id[int'(ADDR_W) - 1 - b];
         ror[b] = id[(b + 1) % int'(ADDR_W)];
         rol[b] = id[(b + int'(ADDR_W) - 1) % int'(ADDR_W)];
      end
      case (sel)
         PatComplement: dst_of = ~id;
         PatReverse:    dst_of = rev;
         PatRotation:   dst_of = ror;
         PatShuffle:    dst_of = rol;
         PatTornado:    dst_of = id + ADDR_W'(PE_NUM / 2 - 1);
         PatNeighbor:   dst_of = id + ADDR_W'(1);
         PatHotspot:    dst_of = hot;
         default:       dst_of = id;
      endcase
   endfunction

   // Compute the configuration that an accepted start will latch.
   always_comb begin
      dst_seq_d = '0;
      send_d    = '0;
      recv_d    = '0;
      // The hotspot receives from every other PE; clamp to the count field.
      hot_prod  = ProdW'(PE_NUM - 1) * ProdW'(cfg_num);
      hot_recv  = (hot_prod > ProdW'({NUM_W{1'b1}})) ? {NUM_W{1'b1}} : hot_prod[NUM_W-1:0];
      for (int i = 0; i < int'(PE_NUM); i++) begin
         dst_seq_d[i*SeqW +: SeqW] = {SEQ_LEN{dst_of(ADDR_W'(i), pattern_sel, hotspot_id)}};
         if (pattern_sel == PatHotspot) begin
            if (ADDR_W'(i) == hotspot_id) begin
               send_d[i*NUM_W +: NUM_W] = '0;
               recv_d[i*NUM_W +: NUM_W] = hot_recv;
            end else begin
               send_d[i*NUM_W +: NUM_W] = cfg_num;
               recv_d[i*NUM_W +: NUM_W] = '0;
            end
         end else begin
            send_d[i*NUM_W +: NUM_W] = cfg_num;
            recv_d[i*NUM_W +: NUM_W] = cfg_num;
         end
      end
   end

   // Capture configuration on the start-accept edge and hold it for the whole run.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pe_dst_seq_wire     <= '0;
         pe_send_num_wire    <= '0;
         pe_receive_num_wire <= '0;
         pe_rate_wire        <= '0;
         pe_mode_wire        <= '0;
         pe_dbg_mode_wire    <= '0;
         lim_q               <= '0;
      end else if (accept) begin
         pe_dst_seq_wire     <= dst_seq_d;
         pe_send_num_wire    <= send_d;
         pe_receive_num_wire <= recv_d;
         pe_rate_wire        <= {PE_NUM{cfg_rate}};
         pe_mode_wire        <= {PE_NUM{cfg_mode}};
         pe_dbg_mode_wire    <= {PE_NUM{cfg_dbg}};
         lim_q               <= timeout_lim;
      end
   end

   // Run sequencer: flush, settle, run until all PEs finish or the limit hits, then pulse done.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= StIdle;
         timer_q       <= '0;
         pe_enable     <= '0;
         pe_flush_wire <= '1;
         done          <= 1'b0;
         timeout       <= 1'b0;
         cycle_count   <= '0;
      end else begin
         done <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (start) begin
                  state_q       <= StFlush;
                  timer_q       <= PhW'(FLUSH_CYC - 1);
                  pe_flush_wire <= '1;
                  timeout       <= 1'b0;
                  cycle_count   <= '0;
               end
            end
            StFlush: begin
               if (timer_q == '0) begin
                  state_q       <= StSettle;
                  timer_q       <= PhW'(SETTLE_CYC - 1);
                  pe_flush_wire <= '0;
               end else begin
                  timer_q <= timer_q - PhW'(1);
               end
            end
            StSettle: begin
               if (timer_q == '0) begin
                  state_q   <= StRun;
                  pe_enable <= '1;
               end else begin
                  timer_q <= timer_q - PhW'(1);
               end
            end
            StRun: begin
               cycle_count <= cnt_inc;
               // cycle_count is still zero in the first RUN cycle, masking stale flags.
               if ((cycle_count != '0) && all_finished) begin
                  state_q   <= StDone;
                  pe_enable <= '0;
                  done      <= 1'b1;
               end else if ((lim_q != '0) && (cnt_inc == lim_q)) begin
                  state_q   <= StDone;
                  pe_enable <= '0;
                  done      <= 1'b1;
                  timeout   <= 1'b1;
               end
            end
            StDone: begin
               state_q <= StIdle;
            end
            default: begin
               state_q <= StIdle;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mesh_traffic_ctrl.sv
// Directed self-checking bench for mesh_traffic_ctrl with default parameters (8 PEs).
module tb_mesh_traffic_ctrl;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [2:0]  pattern_sel = 3'd0;
   logic [2:0]  cfg_num = 3'd1;
   logic [3:0]  cfg_rate = 4'd0;
   logic [3:0]  cfg_mode = 4'd0;
   logic        cfg_dbg = 1'b0;
   logic [2:0]  hotspot_id = 3'd0;
   logic [15:0] timeout_lim = 16'd0;
   logic [7:0]  fin_send = 8'h00;
   logic [7:0]  fin_recv = 8'h00;

   logic [7:0]   pe_enable;
   logic [7:0]   pe_dbg_mode_wire;
   logic [23:0]  pe_send_num_wire;
   logic [23:0]  pe_receive_num_wire;
   logic [31:0]  pe_rate_wire;
   logic [191:0] pe_dst_seq_wire;
   logic [31:0]  pe_mode_wire;
   logic [7:0]   pe_flush_wire;
   logic         busy;
   logic         done;
   logic         timeout;
   logic [15:0]  cycle_count;

   int n_tests = 0;
   int n_fail  = 0;

   mesh_traffic_ctrl dut (
      .clk                         (clk),
      .rst_n                       (rst_n),
      .start                       (start),
      .pattern_sel                 (pattern_sel),
      .cfg_num                     (cfg_num),
      .cfg_rate                    (cfg_rate),
      .cfg_mode                    (cfg_mode),
      .cfg_dbg                     (cfg_dbg),
      .hotspot_id                  (hotspot_id),
      .timeout_lim                 (timeout_lim),
      .pe_enable                   (pe_enable),
      .pe_dbg_mode_wire            (pe_dbg_mode_wire),
      .pe_send_num_wire            (pe_send_num_wire),
      .pe_receive_num_wire         (pe_receive_num_wire),
      .pe_rate_wire                (pe_rate_wire),
      .pe_dst_seq_wire             (pe_dst_seq_wire),
      .pe_mode_wire                (pe_mode_wire),
      .pe_flush_wire               (pe_flush_wire),
      .pe_task_send_finish_flag    (fin_send),
      .pe_task_receive_finish_flag (fin_recv),
      .busy                        (busy),
      .done                        (done),
      .timeout                     (timeout),
      .cycle_count                 (cycle_count)
   );

   always #5 clk = ~clk;

   // All eight 3-bit destination entries of one PE.
   function automatic logic [23:0] dst_slice(input int pe);
      return pe_dst_seq_wire[pe*24 +: 24];
   endfunction

   function automatic logic [2:0] send_at(input int pe);
      return pe_send_num_wire[pe*3 +: 3];
   endfunction

   function automatic logic [2:0] recv_at(input int pe);
      return pe_receive_num_wire[pe*3 +: 3];
   endfunction

   task automatic launch();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_enable(output bit ok);
      ok = 1'b0;
      for (int k = 0; k < 100; k++) begin
         if (pe_enable === 8'hFF) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
   endtask

   task automatic run_to_done(output bit ok);
      fin_send = 8'hFF;
      fin_recv = 8'hFF;
      ok = 1'b0;
      for (int k = 0; k < 200; k++) begin
         @(negedge clk);
         if (done === 1'b1) begin
            ok = 1'b1;
            break;
         end
      end
      fin_send = 8'h00;
      fin_recv = 8'h00;
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      fin_send = 8'h00;
      fin_recv = 8'h00;
      start = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_reset();
      do_reset();
      n_tests++; if (pe_flush_wire !== 8'hFF) begin n_fail++; $display("FAIL rst_flush: got %h exp ff", pe_flush_wire); end
      n_tests++; if (pe_enable !== 8'h00) begin n_fail++; $display("FAIL rst_enable: got %h exp 00", pe_enable); end
      n_tests++; if ({busy, done, timeout} !== 3'b000) begin n_fail++; $display("FAIL rst_status: got %b exp 000", {busy, done, timeout}); end
      n_tests++; if (cycle_count !== 16'd0) begin n_fail++; $display("FAIL rst_count: got %0d exp 0", cycle_count); end
      n_tests++; if (pe_dst_seq_wire !== '0) begin n_fail++; $display("FAIL rst_dst: got %h exp 0", pe_dst_seq_wire); end
      n_tests++; if ({pe_send_num_wire, pe_receive_num_wire, pe_dbg_mode_wire} !== '0) begin n_fail++; $display("FAIL rst_cfg: got %h exp 0", {pe_send_num_wire, pe_receive_num_wire, pe_dbg_mode_wire}); end
   endtask

   task automatic test_complement();
      logic [2:0] e;
      pattern_sel = 3'd0; cfg_num = 3'd1; cfg_rate = 4'd5; cfg_mode = 4'd9; cfg_dbg = 1'b1;
      timeout_lim = 16'd0;
      launch();
      // Now one half-cycle after the accept edge.
      n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL cmp_busy: got %b exp 1", busy); end
      for (int c = 0; c < 4; c++) begin
         n_tests++; if (pe_flush_wire !== 8'hFF) begin n_fail++; $display("FAIL cmp_flush_hi%0d: got %h exp ff", c, pe_flush_wire); end
         @(negedge clk);
      end
      n_tests++; if (pe_flush_wire !== 8'h00) begin n_fail++; $display("FAIL cmp_flush_lo: got %h exp 00", pe_flush_wire); end
      e = 3'd7;
      n_tests++; if (dst_slice(0) !== {8{e}}) begin n_fail++; $display("FAIL cmp_dst_pe0: got %h exp %h", dst_slice(0), {8{e}}); end
      e = 3'd2;
      n_tests++; if (dst_slice(5) !== {8{e}}) begin n_fail++; $display("FAIL cmp_dst_pe5: got %h exp %h", dst_slice(5), {8{e}}); end
      n_tests++; if (pe_send_num_wire !== 24'o11111111) begin n_fail++; $display("FAIL cmp_send: got %h exp 249249", pe_send_num_wire); end
      n_tests++; if (pe_receive_num_wire !== 24'o11111111) begin n_fail++; $display("FAIL cmp_recv: got %h exp 249249", pe_receive_num_wire); end
      n_tests++; if ({pe_rate_wire, pe_mode_wire, pe_dbg_mode_wire} !== {32'h55555555, 32'h99999999, 8'hFF}) begin n_fail++; $display("FAIL cmp_rate_mode_dbg: got %h %h %h exp 55555555 99999999 ff", pe_rate_wire, pe_mode_wire, pe_dbg_mode_wire); end
      repeat (49) @(negedge clk);
      n_tests++; if (pe_enable !== 8'h00) begin n_fail++; $display("FAIL cmp_enable_early: got %h exp 00", pe_enable); end
      @(negedge clk);
      n_tests++; if (pe_enable !== 8'hFF) begin n_fail++; $display("FAIL cmp_enable_54: got %h exp ff", pe_enable); end
      // Mid-run input changes must not reach the latched configuration.
      pattern_sel = 3'd7; cfg_num = 3'd5; cfg_rate = 4'd0;
      repeat (9) @(negedge clk);
      e = 3'd7;
      n_tests++; if ({dst_slice(0), send_at(3), pe_rate_wire[3:0]} !== {{8{e}}, 3'd1, 4'd5}) begin n_fail++; $display("FAIL cmp_hold_cfg: got %h %h %h exp %h 1 5", dst_slice(0), send_at(3), pe_rate_wire[3:0], {8{e}}); end
      n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL cmp_done_early: got %b exp 0", done); end
      fin_send = 8'hFF; fin_recv = 8'hFF;
      @(negedge clk);
      n_tests++; if ({done, pe_enable} !== {1'b1, 8'h00}) begin n_fail++; $display("FAIL cmp_done: got %b %h exp 1 00", done, pe_enable); end
      n_tests++; if (cycle_count !== 16'd10) begin n_fail++; $display("FAIL cmp_count: got %0d exp 10", cycle_count); end
      fin_send = 8'h00; fin_recv = 8'h00;
      @(negedge clk);
      n_tests++; if ({done, busy, timeout, pe_flush_wire} !== {3'b000, 8'h00}) begin n_fail++; $display("FAIL cmp_after: got %b %b %b %h exp 0 0 0 00", done, busy, timeout, pe_flush_wire); end
   endtask

   task automatic test_tornado_rotation();
      logic [2:0] e;
      bit ok;
      pattern_sel = 3'd4; cfg_num = 3'd2; timeout_lim = 16'd0;
      launch();
      e = 3'd0;
      n_tests++; if (dst_slice(5) !== {8{e}}) begin n_fail++; $display("FAIL tor_pe5: got %h exp %h", dst_slice(5), {8{e}}); end
      e = 3'd3;
      n_tests++; if (dst_slice(0) !== {8{e}}) begin n_fail++; $display("FAIL tor_pe0: got %h exp %h", dst_slice(0), {8{e}}); end
      run_to_done(ok);
      n_tests++; if (ok !== 1'b1) begin n_fail++; $display("FAIL tor_done: got %b exp 1", ok); end
      pattern_sel = 3'd2;
      launch();
      e = 3'd4;
      n_tests++; if (dst_slice(1) !== {8{e}}) begin n_fail++; $display("FAIL rot_pe1: got %h exp %h", dst_slice(1), {8{e}}); end
      e = 3'd3;
      n_tests++; if (dst_slice(6) !== {8{e}}) begin n_fail++; $display("FAIL rot_pe6: got %h exp %h", dst_slice(6), {8{e}}); end
      run_to_done(ok);
      n_tests++; if (ok !== 1'b1) begin n_fail++; $display("FAIL rot_done: got %b exp 1", ok); end
   endtask

   task automatic test_hotspot();
      logic [2:0] e;
      bit ok;
      pattern_sel = 3'd6; hotspot_id = 3'd0; cfg_num = 3'd1; timeout_lim = 16'd0;
      launch();
      n_tests++; if ({send_at(0), recv_at(0)} !== {3'd0, 3'd7}) begin n_fail++; $display("FAIL hot0_pe0: got send %0d recv %0d exp 0 7", send_at(0), recv_at(0)); end
      n_tests++; if ({send_at(1), recv_at(1), send_at(7), recv_at(7)} !== {3'd1, 3'd0, 3'd1, 3'd0}) begin n_fail++; $display("FAIL hot0_others: got %0d %0d %0d %0d exp 1 0 1 0", send_at(1), recv_at(1), send_at(7), recv_at(7)); end
      e = 3'd0;
      n_tests++; if (dst_slice(3) !== {8{e}}) begin n_fail++; $display("FAIL hot0_dst: got %h exp %h", dst_slice(3), {8{e}}); end
      run_to_done(ok);
      n_tests++; if (ok !== 1'b1) begin n_fail++; $display("FAIL hot0_done: got %b exp 1", ok); end
      hotspot_id = 3'd2; cfg_num = 3'd3;
      launch();
      n_tests++; if ({send_at(2), recv_at(2)} !== {3'd0, 3'd7}) begin n_fail++; $display("FAIL hot2_sat: got send %0d recv %0d exp 0 7", send_at(2), recv_at(2)); end
      n_tests++; if ({send_at(0), recv_at(0)} !== {3'd3, 3'd0}) begin n_fail++; $display("FAIL hot2_pe0: got send %0d recv %0d exp 3 0", send_at(0), recv_at(0)); end
      e = 3'd2;
      n_tests++; if (dst_slice(7) !== {8{e}}) begin n_fail++; $display("FAIL hot2_dst: got %h exp %h", dst_slice(7), {8{e}}); end
      run_to_done(ok);
      n_tests++; if (ok !== 1'b1) begin n_fail++; $display("FAIL hot2_done: got %b exp 1", ok); end
   endtask

   task automatic test_timeout();
      bit ok;
      pattern_sel = 3'd5; cfg_num = 3'd1; timeout_lim = 16'd20;
      launch();
      wait_enable(ok);
      n_tests++; if (ok !== 1'b1) begin n_fail++; $display("FAIL to_enable: got %b exp 1", ok); end
      repeat (19) @(negedge clk);
      n_tests++; if ({done, timeout, cycle_count} !== {2'b00, 16'd19}) begin n_fail++; $display("FAIL to_pre: got %b %b %0d exp 0 0 19", done, timeout, cycle_count); end
      @(negedge clk);
      n_tests++; if ({done, timeout, cycle_count} !== {2'b11, 16'd20}) begin n_fail++; $display("FAIL to_fire: got %b %b %0d exp 1 1 20", done, timeout, cycle_count); end
      @(negedge clk);
      n_tests++; if ({done, timeout, busy} !== 3'b010) begin n_fail++; $display("FAIL to_sticky: got %b exp 010", {done, timeout, busy}); end
      timeout_lim = 16'd0;
      launch();
      n_tests++; if ({timeout, cycle_count} !== {1'b0, 16'd0}) begin n_fail++; $display("FAIL to_clear: got %b %0d exp 0 0", timeout, cycle_count); end
      run_to_done(ok);
      n_tests++; if (ok !== 1'b1) begin n_fail++; $display("FAIL to_rerun: got %b exp 1", ok); end
   endtask

   task automatic test_same_cycle();
      bit ok;
      timeout_lim = 16'd10;
      launch();
      wait_enable(ok);
      n_tests++; if (ok !== 1'b1) begin n_fail++; $display("FAIL tie_enable: got %b exp 1", ok); end
      repeat (9) @(negedge clk);
      fin_send = 8'hFF; fin_recv = 8'hFF;
      @(negedge clk);
      n_tests++; if ({done, timeout, cycle_count} !== {2'b10, 16'd10}) begin n_fail++; $display("FAIL tie_result: got %b %b %0d exp 1 0 10", done, timeout, cycle_count); end
      fin_send = 8'h00; fin_recv = 8'h00;
      @(negedge clk);
      timeout_lim = 16'd0;
   endtask

   task automatic test_first_cycle();
      bit ok;
      // Stale flags already high when RUN begins must not end it in cycle 1.
      fin_send = 8'hFF; fin_recv = 8'hFF;
      launch();
      wait_enable(ok);
      n_tests++; if (ok !== 1'b1) begin n_fail++; $display("FAIL fc_enable: got %b exp 1", ok); end
      @(negedge clk);
      n_tests++; if ({done, cycle_count} !== {1'b0, 16'd1}) begin n_fail++; $display("FAIL fc_ignored: got %b %0d exp 0 1", done, cycle_count); end
      @(negedge clk);
      n_tests++; if ({done, cycle_count} !== {1'b1, 16'd2}) begin n_fail++; $display("FAIL fc_done: got %b %0d exp 1 2", done, cycle_count); end
      fin_send = 8'h00; fin_recv = 8'h00;
      @(negedge clk);
   endtask

   task automatic test_back_to_back();
      bit ok;
      fin_send = 8'hFF; fin_recv = 8'hFF;
      launch();
      ok = 1'b0;
      for (int k = 0; k < 200; k++) begin
         @(negedge clk);
         if (done === 1'b1) begin
            ok = 1'b1;
            break;
         end
      end
      n_tests++; if (ok !== 1'b1) begin n_fail++; $display("FAIL b2b_done: got %b exp 1", ok); end
      fin_send = 8'h00; fin_recv = 8'h00;
      start = 1'b1;
      @(negedge clk);
      n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL b2b_idle: got %b exp 0", busy); end
      @(negedge clk);
      start = 1'b0;
      n_tests++; if ({busy, pe_flush_wire} !== {1'b1, 8'hFF}) begin n_fail++; $display("FAIL b2b_accept: got %b %h exp 1 ff", busy, pe_flush_wire); end
      run_to_done(ok);
      n_tests++; if (ok !== 1'b1) begin n_fail++; $display("FAIL b2b_second: got %b exp 1", ok); end
   endtask

   task automatic test_start_busy_and_reset();
      bit ok;
      timeout_lim = 16'd0;
      launch();
      wait_enable(ok);
      n_tests++; if (ok !== 1'b1) begin n_fail++; $display("FAIL sb_enable: got %b exp 1", ok); end
      start = 1'b1;
      repeat (3) @(negedge clk);
      start = 1'b0;
      n_tests++; if ({busy, pe_enable, cycle_count} !== {1'b1, 8'hFF, 16'd3}) begin n_fail++; $display("FAIL sb_ignored: got %b %h %0d exp 1 ff 3", busy, pe_enable, cycle_count); end
      rst_n = 1'b0;
      #1;
      n_tests++; if ({busy, pe_enable, pe_flush_wire} !== {1'b0, 8'h00, 8'hFF}) begin n_fail++; $display("FAIL sb_reset: got %b %h %h exp 0 00 ff", busy, pe_enable, pe_flush_wire); end
      n_tests++; if (cycle_count !== 16'd0) begin n_fail++; $display("FAIL sb_reset_count: got %0d exp 0", cycle_count); end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   initial begin
      test_reset();
      test_complement();
      test_tornado_rotation();
      test_hotspot();
      test_timeout();
      test_same_cycle();
      test_first_cycle();
      test_back_to_back();
      test_start_busy_and_reset();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/mesh_traffic_ctrl.md
Name: mesh_traffic_ctrl

Overview:
Synthesizable traffic-pattern sequencer for an N-PE mesh NoC. It replaces hand-written per-PE configuration vectors with patterns computed from node IDs. It then runs the flush → settle → enable → wait-for-finish sequence and reports completion, timeout and run length. It drives the mesh PE configuration ports directly and is parametrised in PE count, count width and destination-sequence depth.

Parameters:
PE_NUM, 8, number of PEs; power of two, ≥2
ADDR_W, 3, log2(PE_NUM); PE ID width
NUM_W, 3, per-PE send/receive count width
SEQ_LEN, 8, destination entries per PE
RATE_W, 4, per-PE rate field width
MODE_W, 4, per-PE mode field width
FLUSH_CYC, 4, cycles pe_flush_wire is held high
SETTLE_CYC, 50, cycles between flush release and enable
CNT_W, 16, cycle counter and timeout width

Ports:
clk  in  1  clock; all logic on rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  launch request; accepted only in IDLE
pattern_sel  in  3  0 complement, 1 reverse, 2 rotation, 3 shuffle, 4 tornado, 5 neighbor, 6 hotspot, 7 loopback
cfg_num  in  NUM_W  packets per sender
cfg_rate  in  RATE_W  rate for every PE
cfg_mode  in  MODE_W  mode for every PE
cfg_dbg  in  1  debug-mode bit for every PE
hotspot_id  in  ADDR_W  hotspot target
timeout_lim  in  CNT_W  RUN-cycle limit; 0 disables timeout
pe_enable  out  PE_NUM  PE enable
pe_dbg_mode_wire  out  PE_NUM  debug mode
pe_send_num_wire  out  PE_NUM*NUM_W  send counts
pe_receive_num_wire  out  PE_NUM*NUM_W  receive counts
pe_rate_wire  out  PE_NUM*RATE_W  rates
pe_dst_seq_wire  out  PE_NUM*SEQ_LEN*ADDR_W  destination sequences
pe_mode_wire  out  PE_NUM*MODE_W  modes
pe_flush_wire  out  PE_NUM  PE flush
pe_task_send_finish_flag  in  PE_NUM  per-PE send done
pe_task_receive_finish_flag  in  PE_NUM  per-PE receive done
busy  out  1  high in any state other than IDLE
done  out  1  one-cycle pulse at run end
timeout  out  1  sticky; cleared by the next accepted start
cycle_count  out  CNT_W  RUN cycles of the last run; saturates at all ones

Behaviour:
- Reset (async, any state): FSM goes to IDLE. pe_flush_wire is all ones. All other outputs are 0, including cycle_count.
- Packing: PE i occupies slice i of each bus (LSB = PE0). Destination entry j of PE i is at bit offset (i*SEQ_LEN+j)*ADDR_W. All SEQ_LEN entries of PE i equal dst(i).
- dst(i), with arithmetic mod PE_NUM:
  - complement: ~i
  - reverse: bit-reverse of i
  - rotation: rotate i right by 1
  - shuffle: rotate i left by 1
  - tornado: i + PE_NUM/2 − 1
  - neighbor: i + 1
  - hotspot: hotspot_id
  - loopback: i
- Counts, patterns 0-5 and 7: send = receive = cfg_num for every PE.
- Counts, hotspot:
  - PE hotspot_id: send 0; receive = (PE_NUM−1)*cfg_num, saturated to 2^NUM_W−1.
  - All other PEs: send cfg_num, receive 0.
- Config capture: all config outputs and inputs are registered on the start-accept edge and held until the next accepted start. Input changes mid-run are ignored.
- FSM states:
  - IDLE: start=1 → FLUSH. This edge latches config, clears timeout and clears cycle_count.
  - FLUSH: pe_flush_wire all ones for FLUSH_CYC cycles → SETTLE.
  - SETTLE: pe_flush_wire 0 for SETTLE_CYC cycles → RUN.
  - RUN: pe_enable all ones; cycle_count increments each cycle, saturating. Flags are ignored in the first RUN cycle.
    - From the second cycle, &send_flags & &receive_flags → DONE.
    - Otherwise, if timeout_lim≠0 and cycle_count==timeout_lim → timeout set, go to DONE.
    - If completion and timeout occur in the same cycle, completion wins and timeout stays 0.
  - DONE (1 cycle): pe_enable 0, done=1 → IDLE. pe_flush_wire stays 0 until the next FLUSH.
- start while busy: ignored, with no queuing.
- A start asserted in the same cycle DONE returns to IDLE is not accepted until the next cycle, because the FSM is then in IDLE.

Test Plan:
- Complement, cfg_num=1, PE_NUM=8, start → PE0 dst entries all 7, PE5 all 2. Flush high 4 cycles, enable rises 54 cycles after accept. Flags all set at RUN cycle 10 → done pulse, cycle_count=10.
- Tornado, then rotation → tornado: PE5→0, PE0→3. Rotation: PE1→4, PE6→3.
- Hotspot, hotspot_id=0, cfg_num=1 → PE0 receive 7, send 0; PE1-7 send 1, receive 0. With cfg_num=3, PE0 receive saturates to 7.
- timeout_lim=20, flags never set → timeout=1, done pulse, cycle_count=20. A new start clears timeout.
- Completion and timeout in the same cycle → done=1, timeout=0.
- start during RUN ignored. rst_n low mid-RUN → pe_enable 0, flush all ones, busy 0 immediately.
